// File: rtl/ysyx_23060184_ifu.sv
// Instruction fetch unit: holds the PC, fetches one word per instruction over a
// valid/ready memory port and hands it to decode, then waits for writeback's next PC.
module ysyx_23060184_ifu #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h8000_0000,
    parameter int                    TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  Wvalid,
    input  logic [DATA_WIDTH-1:0] PCNext,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic                  imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] imem_rsp_data,
    input  logic                  imem_rsp_err,
    output logic [DATA_WIDTH-1:0] inst,
    output logic [DATA_WIDTH-1:0] PC,
    output logic [DATA_WIDTH-1:0] PCPlus4,
    output logic                  Ivalid,
    input  logic                  Dready,
    output logic                  Ifault,
    output logic [31:0]           fetch_cnt
);

    localparam logic [DATA_WIDTH-1:0] NOP    = DATA_WIDTH'(32'h0000_0013);
    localparam logic [7:0]            TO_MAX = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_IDLE = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [DATA_WIDTH-1:0] r_pc;
    logic [DATA_WIDTH-1:0] r_inst;
    logic                  r_fault;
    logic [7:0]            r_tcnt;
    logic [31:0]           r_fetch_cnt;

    logic                  w_timeout;
    logic                  w_misaligned;
    logic                  w_rsp_take;
    logic                  w_dec_take;
    logic                  w_wb_take;

    // Timeout fires on the TIMEOUT-th WAIT cycle without a response.
    assign w_timeout    = (r_tcnt + 8'd1) == TO_MAX;
    assign w_misaligned = PCNext[1:0] != 2'b00;

    assign w_rsp_take = (r_state == S_WAIT) && imem_rsp_valid;
    assign w_dec_take = (r_state == S_HOLD) && Dready;
    assign w_wb_take  = (r_state == S_IDLE) && Wvalid;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_REQ;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_REQ: begin
                if (imem_req_ready) begin
                    w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid || w_timeout) begin
                    w_next = S_HOLD;
                end
            end
            S_HOLD: begin
                if (Dready) begin
                    w_next = S_IDLE;
                end
            end
            S_IDLE: begin
                // A misaligned target never reaches memory; it is reported as a fault.
                if (Wvalid) begin
                    w_next = w_misaligned ? S_HOLD : S_REQ;
                end
            end
            default: w_next = S_REQ;
        endcase
    end

    always_comb begin
        imem_req_valid = 1'b0;
        Ivalid         = 1'b0;
        case (r_state)
            S_REQ:   imem_req_valid = 1'b1;
            S_HOLD:  Ivalid         = 1'b1;
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pc <= RESET_PC;
        end else if (w_wb_take) begin
            r_pc <= PCNext;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_inst  <= NOP;
            r_fault <= 1'b0;
        end else if (w_rsp_take) begin
            r_inst  <= imem_rsp_data;
            r_fault <= imem_rsp_err;
        end else if (((r_state == S_WAIT) && w_timeout) || (w_wb_take && w_misaligned)) begin
            r_inst  <= NOP;
            r_fault <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_tcnt <= 8'd0;
        end else if ((r_state == S_REQ) && imem_req_ready) begin
            r_tcnt <= 8'd0;
        end else if ((r_state == S_WAIT) && !imem_rsp_valid && !w_timeout) begin
            r_tcnt <= r_tcnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_fetch_cnt <= 32'd0;
        end else if (w_dec_take) begin
            r_fetch_cnt <= r_fetch_cnt + 32'd1;
        end
    end

    assign imem_addr = r_pc;
    assign PC        = r_pc;
    assign PCPlus4   = r_pc + DATA_WIDTH'(4);
    assign inst      = r_inst;
    assign Ifault    = r_fault;
    assign fetch_cnt = r_fetch_cnt;

endmodule

// File: tb/tb_ysyx_23060184_ifu.sv
// Directed bench for the fetch unit; a monitor scores request addresses and decode
// handshakes against queues filled by the stimulus.
module tb_ysyx_23060184_ifu;

    logic        clk;
    logic        rstn;
    logic        Wvalid;
    logic [31:0] PCNext;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic [31:0] inst;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        Ivalid;
    logic        Dready;
    logic        Ifault;
    logic [31:0] fetch_cnt;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] pcp4;
        logic        fault;
        logic [31:0] cnt;
    } dec_t;

    logic [31:0] req_q[$];
    dec_t        dec_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] mon_addr;
    dec_t        mon_dec;

    ysyx_23060184_ifu #(
        .DATA_WIDTH(32),
        .RESET_PC  (32'h8000_0000),
        .TIMEOUT   (4)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .Wvalid        (Wvalid),
        .PCNext        (PCNext),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_addr     (imem_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .imem_rsp_err  (imem_rsp_err),
        .inst          (inst),
        .PC            (PC),
        .PCPlus4       (PCPlus4),
        .Ivalid        (Ivalid),
        .Dready        (Dready),
        .Ifault        (Ifault),
        .fetch_cnt     (fetch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got no summary, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_dec(input logic [31:0] i, input logic [31:0] p, input logic [31:0] p4,
                            input logic f, input logic [31:0] c);
        dec_t d;
        d.inst  = i;
        d.pc    = p;
        d.pcp4  = p4;
        d.fault = f;
        d.cnt   = c;
        dec_q.push_back(d);
    endtask

    // Full fetch from IDLE: writeback, optional request stall, response next cycle, decode accept.
    task automatic fetch(input logic [31:0] pc, input logic [31:0] pcp4, input int stall,
                         input logic [31:0] data, input logic err, input logic [31:0] cnt);
        Wvalid = 1'b1;
        PCNext = pc;
        step();
        Wvalid = 1'b0;
        req_q.push_back(pc);
        imem_req_ready = 1'b0;
        for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            chk("req_stall_valid", 32'(imem_req_valid), 32'd1);
            chk("req_stall_addr", imem_addr, pc);
            step();
        end
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = data;
        imem_rsp_err   = err;
        push_dec(data, pc, pcp4, err, cnt);
        step();
        imem_rsp_valid = 1'b0;
        imem_rsp_err   = 1'b0;
        Dready         = 1'b1;
        step();
        Dready = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rstn === 1'b1) begin
            if (imem_req_valid && imem_req_ready) begin
                if (req_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL req_unexpected: got request at %h, required none", imem_addr);
                end else begin
                    mon_addr = req_q.pop_front();
                    chk("req_addr", imem_addr, mon_addr);
                end
            end
            if (Ivalid && Dready) begin
                if (dec_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL dec_unexpected: got inst %h pc %h, required none", inst, PC);
                end else begin
                    mon_dec = dec_q.pop_front();
                    chk("dec_inst", inst, mon_dec.inst);
                    chk("dec_pc", PC, mon_dec.pc);
                    chk("dec_pcplus4", PCPlus4, mon_dec.pcp4);
                    chk("dec_fault", 32'(Ifault), 32'(mon_dec.fault));
                    chk("dec_fetch_cnt", fetch_cnt, mon_dec.cnt);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rstn === 1'b1) begin
            assert (!(Ivalid && Dready && Wvalid))
            else $error("writeback completion coincides with decode accept");
        end
    end

    initial begin
        rstn           = 1'b0;
        Wvalid         = 1'b0;
        PCNext         = 32'h0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        imem_rsp_err   = 1'b0;
        Dready         = 1'b0;

        repeat (3) step();
        @(negedge clk);
        chk("rst_ivalid", 32'(Ivalid), 32'd0);
        chk("rst_ifault", 32'(Ifault), 32'd0);
        chk("rst_fetch_cnt", fetch_cnt, 32'd0);
        chk("rst_inst", inst, 32'h0000_0013);
        chk("rst_pc", PC, 32'h8000_0000);

        // First fetch: memory ready at once; a response in the handshake cycle is ignored.
        step();
        rstn           = 1'b1;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0BAD_0BAD;
        req_q.push_back(32'h8000_0000);
        @(negedge clk);
        chk("first_req_valid", 32'(imem_req_valid), 32'd1);
        step();
        imem_req_ready = 1'b0;
        imem_rsp_data  = 32'h0010_0093;
        push_dec(32'h0010_0093, 32'h8000_0000, 32'h8000_0004, 1'b0, 32'd0);
        @(negedge clk);
        chk("wait_ivalid", 32'(Ivalid), 32'd0);
        chk("wait_req_valid", 32'(imem_req_valid), 32'd0);
        step();
        imem_rsp_valid = 1'b0;

        // Decode stalls 5 cycles; stray writeback and response must not disturb the held word.
        for (int i = 0; i < 5; i++) begin
            Wvalid         = (i == 2);
            PCNext         = 32'h1234_5678;
            imem_rsp_valid = (i == 3);
            imem_rsp_data  = 32'hDEAD_BEEF;
            @(negedge clk);
            chk("hold_ivalid", 32'(Ivalid), 32'd1);
            chk("hold_inst", inst, 32'h0010_0093);
            chk("hold_pc", PC, 32'h8000_0000);
            step();
        end
        Wvalid         = 1'b0;
        imem_rsp_valid = 1'b0;
        Dready         = 1'b1;
        step();
        Dready = 1'b0;
        @(negedge clk);
        chk("idle_ivalid", 32'(Ivalid), 32'd0);
        chk("idle_fetch_cnt", fetch_cnt, 32'd1);

        // Stray decode-ready and response in IDLE.
        step();
        Dready         = 1'b1;
        imem_rsp_valid = 1'b1;
        step();
        Dready         = 1'b0;
        imem_rsp_valid = 1'b0;
        @(negedge clk);
        chk("idle_stray_cnt", fetch_cnt, 32'd1);
        chk("idle_stray_req", 32'(imem_req_valid), 32'd0);
        step();

        fetch(32'h8000_0100, 32'h8000_0104, 3, 32'h0020_0113, 1'b0, 32'd1);

        // No response: TIMEOUT=4 WAIT cycles then a faulting nop.
        Wvalid = 1'b1;
        PCNext = 32'h8000_0200;
        step();
        Wvalid         = 1'b0;
        imem_req_ready = 1'b1;
        req_q.push_back(32'h8000_0200);
        step();
        imem_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("timeout_wait_ivalid", 32'(Ivalid), 32'd0);
            step();
        end
        @(negedge clk);
        chk("timeout_ivalid", 32'(Ivalid), 32'd1);
        chk("timeout_ifault", 32'(Ifault), 32'd1);
        chk("timeout_inst", inst, 32'h0000_0013);
        push_dec(32'h0000_0013, 32'h8000_0200, 32'h8000_0204, 1'b1, 32'd2);
        step();
        Dready = 1'b1;
        step();
        Dready = 1'b0;

        fetch(32'h8000_0300, 32'h8000_0304, 0, 32'h0000_0073, 1'b1, 32'd3);

        // Misaligned target: straight to HOLD with a fault, no memory request.
        Wvalid = 1'b1;
        PCNext = 32'h8000_0102;
        push_dec(32'h0000_0013, 32'h8000_0102, 32'h8000_0106, 1'b1, 32'd4);
        step();
        Wvalid = 1'b0;
        @(negedge clk);
        chk("misal_req_valid", 32'(imem_req_valid), 32'd0);
        chk("misal_ivalid", 32'(Ivalid), 32'd1);
        chk("misal_ifault", 32'(Ifault), 32'd1);
        step();
        Dready = 1'b1;
        step();
        Dready = 1'b0;

        fetch(32'hFFFF_FFFC, 32'h0000_0000, 0, 32'h0000_0513, 1'b0, 32'd5);

        // Reset while waiting for a response; the late response must be ignored.
        Wvalid = 1'b1;
        PCNext = 32'h8000_0400;
        step();
        Wvalid         = 1'b0;
        imem_req_ready = 1'b1;
        req_q.push_back(32'h8000_0400);
        step();
        imem_req_ready = 1'b0;
        rstn           = 1'b0;
        @(negedge clk);
        chk("rst_mid_addr", imem_addr, 32'h8000_0000);
        chk("rst_mid_cnt", fetch_cnt, 32'd0);
        step();
        rstn = 1'b1;
        step();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0BAD_0BAD;
        @(negedge clk);
        chk("rst_stale_req_valid", 32'(imem_req_valid), 32'd1);
        chk("rst_stale_addr", imem_addr, 32'h8000_0000);
        chk("rst_stale_ivalid", 32'(Ivalid), 32'd0);
        step();
        imem_rsp_valid = 1'b0;
        imem_req_ready = 1'b1;
        req_q.push_back(32'h8000_0000);
        step();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0030_0193;
        push_dec(32'h0030_0193, 32'h8000_0000, 32'h8000_0004, 1'b0, 32'd0);
        step();
        imem_rsp_valid = 1'b0;
        Dready         = 1'b1;
        step();
        Dready = 1'b0;
        @(negedge clk);
        chk("rst_after_cnt", fetch_cnt, 32'd1);

        repeat (3) step();
        chk("req_queue_drained", 32'(req_q.size()), 32'd0);
        chk("dec_queue_drained", 32'(dec_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
